// File: rtl/digit_sender_pkg.sv
// Shared constants for the digit readout path: 3-bit state codes, the BCD
// digit ceiling and the default handshake timeout.
package digit_sender_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEND_L = 3'd1;
  localparam logic [2:0] S_REL_L  = 3'd2;
  localparam logic [2:0] S_SEND_R = 3'd3;
  localparam logic [2:0] S_REL_R  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  localparam logic [3:0] BCD_MAX            = 4'd9;
  localparam int         DEF_TIMEOUT_CYCLES = 15;

endpackage

// File: rtl/handshake_timer.sv
// Per-state dwell counter. Cleared on state entry, counts while a handshake
// state is active, flags the last permitted cycle of that state.
module handshake_timer #(
  parameter int CNT_W          = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  // Dwell counter: zero on reset/clear, advance one per running cycle.
  always_ff @(posedge clock) begin
    if (reset || clear) cnt <= '0;
    else if (run)       cnt <= cnt + CNT_W'(1);
  end

  // Terminal cycle: this is the TIMEOUT_CYCLES-th cycle in the state.
  assign expired = run && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/digit_sender.sv
// Sends a latched left/right nibble pair over a 4-bit bus with a four-phase
// valid/ack handshake, left digit first. Every output is registered.
// Optional build macro DIGIT_SENDER_BCD_CHECK_EN: reject digits above 9 at
// acceptance by going straight to ERROR.
module digit_sender
  import digit_sender_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] left,
  input  logic [3:0] right,
  input  logic       ack,
  output logic [3:0] out,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] state
);

  logic [2:0] nxt;
  logic       accept;
  logic       hs;
  logic       expired;
  logic [3:0] l_q, r_q;

  assign hs = (state == S_SEND_L) || (state == S_REL_L) ||
              (state == S_SEND_R) || (state == S_REL_R);

  // Timer restarts whenever the state changes and idles outside handshakes.
  handshake_timer #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (!hs || (nxt != state)),
    .run     (hs),
    .expired (expired)
  );

  // Next-state rules; an exit condition beats the timeout on the last cycle.
  always_comb begin
    nxt    = state;
    accept = 1'b0;
    case (state)
      S_IDLE, S_ERROR: begin
        if (start && !ack) begin
          accept = 1'b1;
          nxt    = S_SEND_L;
`ifdef DIGIT_SENDER_BCD_CHECK_EN
          if ((left > BCD_MAX) || (right > BCD_MAX)) nxt = S_ERROR;
`endif
        end
      end
      S_SEND_L: if (ack)      nxt = S_REL_L;  else if (expired) nxt = S_ERROR;
      S_REL_L:  if (!ack)     nxt = S_SEND_R; else if (expired) nxt = S_ERROR;
      S_SEND_R: if (ack)      nxt = S_REL_R;  else if (expired) nxt = S_ERROR;
      S_REL_R:  if (!ack)     nxt = S_DONE;   else if (expired) nxt = S_ERROR;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // State, digit latches and outputs registered from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      l_q   <= '0;
      r_q   <= '0;
      out   <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        l_q <= left;
        r_q <= right;
      end
      valid <= (nxt == S_SEND_L) || (nxt == S_SEND_R);
      busy  <= (nxt == S_SEND_L) || (nxt == S_REL_L) ||
               (nxt == S_SEND_R) || (nxt == S_REL_R);
      done  <= (nxt == S_DONE);
      error <= (nxt == S_ERROR);
      case (nxt)
        S_SEND_L, S_REL_L: out <= accept ? left : l_q;
        S_SEND_R, S_REL_R: out <= r_q;
        default:           out <= '0;
      endcase
    end
  end

endmodule

// File: doc/digit_sender.md
Name: digit_sender

Overview:
- Readout side of the two-digit entry path: takes a stored left/right nibble pair and transmits it one digit at a time over a 4-bit bus.
- Uses a four-phase valid/ack handshake, left digit first.
- Sits between the left/right digit registers and a downstream consumer (display driver, comparator, serial link).
- Reports progress on a 3-bit state output, matching the entry FSM's style.

Parameters:
- TIMEOUT_CYCLES, 15: maximum cycles spent in any handshake state before aborting to ERROR; legal range 2..2^CNT_W-1.
- CNT_W, 4: width of the timeout counter.

Ports:
- clock  input  1  single system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to send the current left/right pair; sampled only in IDLE or ERROR.
- left   input  4  first digit; latched on start acceptance.
- right  input  4  second digit; latched on start acceptance.
- out    output 4  digit on the bus.
- valid  output 1  out holds a digit awaiting ack.
- ack    input  1  consumer acknowledge (four-phase).
- busy   output 1  high in SEND_L, REL_L, SEND_R, REL_R.
- done   output 1  one-cycle pulse after both digits complete.
- error  output 1  high while in ERROR.
- state  output 3  current FSM state encoding.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE(0), out=0, valid=0, busy=0, done=0, error=0, latched digits=0, timer=0.
- Reset mid-transfer: abandons the transfer at the next edge, with no done and no error.
- Output timing: all outputs are Moore outputs decoded from registered state and registered digit latches; no combinational path from ack or start to any output.
- State encoding: IDLE=0, SEND_L=1, REL_L=2, SEND_R=3, REL_R=4, DONE=5, ERROR=6; 7 is unused and recovers to IDLE.
- IDLE: start=1 and ack=0 latches left/right and moves to SEND_L. start=1 with ack=1 is ignored (stay IDLE).
- SEND_L: valid=1, out=latched left. ack=1 moves to REL_L.
- REL_L: valid=0, out holds left. ack=0 moves to SEND_R.
- SEND_R: valid=1, out=latched right. ack=1 moves to REL_R.
- REL_R: valid=0, out holds right. ack=0 moves to DONE.
- DONE: done=1 for exactly one cycle, out=0, then IDLE. start in DONE is ignored.
- ERROR: error=1, valid=0, out=0. Held until reset, or until start=1 with ack=0, which relatches the digits and goes to SEND_L (same rule as IDLE).
- Latency: start sampled at edge N gives valid=1 in cycle N+1. With ack responding immediately each time, done asserts 5 cycles after the start edge.
- Timeout: the timer clears on every state entry and increments each cycle in the four handshake states. If it reaches TIMEOUT_CYCLES-1 and the exit condition is not met that cycle, go to ERROR. If the exit condition is met on the terminal cycle, the exit wins.
- Input stability: left/right changes after acceptance have no effect on the current transfer. start pulses while busy are dropped, not queued.

Optional Feature:
- Macro: DIGIT_SENDER_BCD_CHECK_EN.
- Defined: at start acceptance, if left>9 or right>9, go directly to ERROR (valid never asserts).
- Undefined: any 4-bit value 0..15 is transmitted unchanged.

Decomposition:
- Package digit_sender_pkg: 3-bit state localparams (IDLE..ERROR), the BCD maximum constant 9, and the default TIMEOUT_CYCLES.
- One sub-module, handshake_timer:
  - parameters CNT_W and TIMEOUT_CYCLES;
  - inputs clear, run;
  - output expired;
  - synchronous active-high reset.
- Everything else stays in digit_sender.

Test Plan:
- Basic send: left=4'h3, right=4'h7, start pulse, ack mirrors valid after 1 cycle -> out=3 with valid, then out=7 with valid; done one cycle; state sequence 0,1,2,3,4,5,0.
- Ignored starts: start while ack=1 in IDLE -> stays IDLE. start pulses during SEND_R -> ignored; no second transfer.
- Timeout: ack held 0 in SEND_L for TIMEOUT_CYCLES -> ERROR (state=6, error=1, valid=0). Then start with left=1, right=2 and normal ack -> full transfer and done.
- Reset mid-operation: reset asserted in REL_L -> next edge all outputs are at reset values, state=0, no done pulse.
- Digit capture: left/right change in the cycle after start -> transmitted digits are the values present at the acceptance edge.
- Optional feature: with DIGIT_SENDER_BCD_CHECK_EN defined, left=4'hA -> ERROR one cycle after start, valid never high. Without the macro, the same stimulus transmits A then right.
